// File: rtl/pc_seq_unit_if.sv
// Bus bundle for pc_seq_unit: instruction/flag inputs and PC/stack status outputs.
// The master side drives instructions; the slave side is the sequencer.
interface pc_seq_unit_if #(
   parameter int unsigned ADDR_W      = 11,
   parameter int unsigned STACK_DEPTH = 4
);
   localparam int unsigned SP_W = $clog2(STACK_DEPTH + 1);

   logic              instr_valid;
   logic [13:0]       instr;
   logic              zf;
   logic              nf;
   logic              cy;
   logic              pc_load;
   logic [ADDR_W-1:0] pc_load_val;
   logic              flag_clr;
   logic [ADDR_W-1:0] pc;
   logic              taken;
   logic              is_bsr;
   logic              is_ret;
   logic [SP_W-1:0]   sp;
   logic              stack_ovf;
   logic              stack_unf;

   modport master (
      output instr_valid, instr, zf, nf, cy, pc_load, pc_load_val, flag_clr,
      input  pc, taken, is_bsr, is_ret, sp, stack_ovf, stack_unf
   );

   modport slave (
      input  instr_valid, instr, zf, nf, cy, pc_load, pc_load_val, flag_clr,
      output pc, taken, is_bsr, is_ret, sp, stack_ovf, stack_unf
   );
endinterface

// File: rtl/pc_seq_unit.sv
// Program-counter sequencer: decodes JMP/JZE/JNE/CCY/BSR/RET, owns the PC and a return stack.
// Define PCSEQ_STACK_WRAP_EN to make the return stack circular (oldest entry overwritten when full).
module pc_seq_unit #(
   parameter int unsigned ADDR_W      = 11,
   parameter int unsigned STACK_DEPTH = 4,
   parameter int unsigned RESET_PC    = 0
) (
   input logic           clk,
   input logic           reset,
   pc_seq_unit_if.slave  bus
);
   localparam int unsigned SP_W  = $clog2(STACK_DEPTH + 1);
   localparam int unsigned PTR_W = $clog2(STACK_DEPTH);
   localparam logic [SP_W-1:0]  SP_FULL  = SP_W'(STACK_DEPTH);
   localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(STACK_DEPTH - 1);

   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [SP_W-1:0]   sp_q, sp_d;
   logic [PTR_W-1:0]  ptr_q, ptr_d;
   logic              ovf_q, ovf_d;
   logic              unf_q, unf_d;
   logic [ADDR_W-1:0] stack_q [STACK_DEPTH];

   logic              cond_ok;
   logic              dec_bsr;
   logic              dec_ret;
   logic              jump_taken;
   logic              stack_full;
   logic              stack_empty;
   logic              push_en;
   logic              ovf_set;
   logic              unf_set;
   logic [ADDR_W-1:0] pc_inc;
   logic [ADDR_W-1:0] target;
   logic [PTR_W-1:0]  ptr_inc;
   logic [PTR_W-1:0]  ptr_dec;

   always_comb begin
      case (bus.instr[12:11])
         2'b00:   cond_ok = 1'b1;
         2'b01:   cond_ok = bus.zf;
         2'b10:   cond_ok = bus.nf;
         default: cond_ok = bus.cy;
      endcase
   end

   assign dec_bsr     = bus.instr_valid & ~bus.instr[13] & (bus.instr[12:10] == 3'b111);
   assign dec_ret     = bus.instr_valid & (bus.instr == 14'h0180);
   assign jump_taken  = bus.instr_valid & bus.instr[13] & cond_ok;
   assign stack_full  = (sp_q == SP_FULL);
   assign stack_empty = (sp_q == '0);
   assign pc_inc      = pc_q + 1'b1;
   assign target      = bus.instr[ADDR_W-1:0];
   // ptr_q is the slot the next push writes; it wraps so the circular build shares this path.
   assign ptr_inc     = (ptr_q == PTR_LAST) ? '0 : ptr_q + 1'b1;
   assign ptr_dec     = (ptr_q == '0) ? PTR_LAST : ptr_q - 1'b1;

   always_comb begin
      pc_d    = pc_q;
      sp_d    = sp_q;
      ptr_d   = ptr_q;
      push_en = 1'b0;
      ovf_set = 1'b0;
      unf_set = 1'b0;
      if (bus.pc_load) begin
         pc_d = bus.pc_load_val;
      end else if (bus.instr_valid) begin
         if (jump_taken) begin
            pc_d = target;
         end else if (dec_bsr) begin
            pc_d = target;
            if (!stack_full) begin
               push_en = 1'b1;
               ptr_d   = ptr_inc;
               sp_d    = sp_q + 1'b1;
            end else begin
               ovf_set = 1'b1;
`ifdef PCSEQ_STACK_WRAP_EN
               push_en = 1'b1;
               ptr_d   = ptr_inc;
`endif
            end
         end else if (dec_ret && !stack_empty) begin
            pc_d  = stack_q[ptr_dec];
            ptr_d = ptr_dec;
            sp_d  = sp_q - 1'b1;
         end else begin
            pc_d    = pc_inc;
            unf_set = dec_ret;
         end
      end
      // A set in the same cycle as flag_clr wins.
      ovf_d = (ovf_q & ~bus.flag_clr) | ovf_set;
      unf_d = (unf_q & ~bus.flag_clr) | unf_set;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pc_q  <= ADDR_W'(RESET_PC);
         sp_q  <= '0;
         ptr_q <= '0;
         ovf_q <= 1'b0;
         unf_q <= 1'b0;
      end else begin
         pc_q  <= pc_d;
         sp_q  <= sp_d;
         ptr_q <= ptr_d;
         ovf_q <= ovf_d;
         unf_q <= unf_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push_en && !reset) begin
         stack_q[ptr_q] <= pc_inc;
      end
   end

   assign bus.pc        = pc_q;
   assign bus.sp        = sp_q;
   assign bus.stack_ovf = ovf_q;
   assign bus.stack_unf = unf_q;
   assign bus.is_bsr    = dec_bsr;
   assign bus.is_ret    = dec_ret;
   assign bus.taken     = jump_taken | dec_bsr | (dec_ret & ~stack_empty);
endmodule

// File: tb/tb_pc_seq_unit.sv
// Randomised scoreboard bench for pc_seq_unit against a queue-based reference model.
module tb_pc_seq_unit;
   localparam int ADDR_W = 11;
   localparam int DEPTH  = 4;
   localparam int MODV   = 1 << ADDR_W;

   logic clk = 1'b0;
   logic reset;

   pc_seq_unit_if #(.ADDR_W(ADDR_W), .STACK_DEPTH(DEPTH)) bus ();

   pc_seq_unit #(.ADDR_W(ADDR_W), .STACK_DEPTH(DEPTH), .RESET_PC(0)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit taken;
      bit is_bsr;
      bit is_ret;
      int pc;
      int sp;
      bit ovf;
      bit unf;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;

   // Reference model state
   int m_pc = 0;
   int m_stk[$];
   bit m_ovf = 0;
   bit m_unf = 0;

   task automatic chk(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
      end
   endtask

   task automatic step(input bit rst, input bit v, input logic [13:0] ins,
                       input bit z, input bit n, input bit c,
                       input bit ld, input int lv, input bit clr);
      exp_t e;
      bit   jmp, ok, bsr, ret, oset, uset;
      int   cnd;
      @(negedge clk);
      reset           = rst;
      bus.instr_valid = v;
      bus.instr       = ins;
      bus.zf          = z;
      bus.nf          = n;
      bus.cy          = c;
      bus.pc_load     = ld;
      bus.pc_load_val = ADDR_W'(lv);
      bus.flag_clr    = clr;

      jmp = ins[13];
      cnd = int'(ins[12:11]);
      ok  = (cnd == 0) || (cnd == 1 && z) || (cnd == 2 && n) || (cnd == 3 && c);
      bsr = !ins[13] && (ins[12:10] == 3'b111);
      ret = (ins == 14'h0180);
      e.is_bsr = v && bsr;
      e.is_ret = v && ret;
      e.taken  = v && ((jmp && ok) || bsr || (ret && m_stk.size() > 0));

      oset = 0;
      uset = 0;
      if (rst) begin
         m_pc = 0;
         m_stk.delete();
         m_ovf = 0;
         m_unf = 0;
      end else begin
         if (ld) begin
            m_pc = lv % MODV;
         end else if (v) begin
            if (jmp) begin
               m_pc = ok ? (int'(ins) % MODV) : (m_pc + 1) % MODV;
            end else if (bsr) begin
               if (m_stk.size() < DEPTH) begin
                  m_stk.push_back((m_pc + 1) % MODV);
               end else begin
                  oset = 1;
`ifdef PCSEQ_STACK_WRAP_EN
                  void'(m_stk.pop_front());
                  m_stk.push_back((m_pc + 1) % MODV);
`endif
               end
               m_pc = int'(ins) % MODV;
            end else if (ret && m_stk.size() > 0) begin
               m_pc = m_stk.pop_back();
            end else begin
               if (ret) uset = 1;
               m_pc = (m_pc + 1) % MODV;
            end
         end
         if (clr) begin
            m_ovf = 0;
            m_unf = 0;
         end
         if (oset) m_ovf = 1;
         if (uset) m_unf = 1;
      end
      e.pc  = m_pc;
      e.sp  = m_stk.size();
      e.ovf = m_ovf;
      e.unf = m_unf;
      exp_q.push_back(e);
   endtask

   task automatic ex(input logic [13:0] ins, input bit z);
      step(0, 1, ins, z, 0, 0, 0, 0, 0);
   endtask

   task automatic load(input int lv);
      step(0, 0, 14'h0000, 0, 0, 0, 1, lv, 0);
   endtask

   // Monitor: combinational decode checked before the edge, registered state just after it.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         #3;
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("taken", int'(bus.taken), int'(e.taken));
            chk("is_bsr", int'(bus.is_bsr), int'(e.is_bsr));
            chk("is_ret", int'(bus.is_ret), int'(e.is_ret));
            @(posedge clk);
            #1;
            chk("pc", int'(bus.pc), e.pc);
            chk("sp", int'(bus.sp), e.sp);
            chk("stack_ovf", int'(bus.stack_ovf), int'(e.ovf));
            chk("stack_unf", int'(bus.stack_unf), int'(e.unf));
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [13:0] ins;
      int          r;
      reset           = 1'b1;
      bus.instr_valid = 1'b0;
      bus.instr       = '0;
      bus.zf          = 1'b0;
      bus.nf          = 1'b0;
      bus.cy          = 1'b0;
      bus.pc_load     = 1'b0;
      bus.pc_load_val = '0;
      bus.flag_clr    = 1'b0;

      step(1, 0, 14'h0000, 0, 0, 0, 0, 0, 0);
      repeat (3) ex(14'h0000, 0);
      load(5);
      ex(14'h2010, 0);
      ex(14'h2820, 0);
      ex(14'h2820, 1);
      load(12'h040);
      ex(14'h1C80, 0);
      ex(14'h0180, 0);
      for (int i = 0; i < 5; i++) ex(14'(14'h1C10 + 14'(i * 16)), 0);
      for (int i = 0; i < 5; i++) ex(14'h0180, 0);
      step(0, 0, 14'h0000, 0, 0, 0, 0, 0, 1);
      ex(14'h1C80, 0);
      step(0, 1, 14'h1C80, 0, 0, 0, 1, 12'h123, 0);
      load(12'h7FF);
      ex(14'h0000, 0);
      step(1, 0, 14'h0000, 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 6; i++) ex(14'(14'h1C20 + 14'(i * 32)), 0);
      for (int i = 0; i < 5; i++) ex(14'h0180, 0);
      step(0, 0, 14'h0000, 0, 0, 0, 0, 0, 1);

      for (int i = 0; i < 400; i++) begin
         r = $urandom_range(0, 99);
         if (r < 25)      ins = {1'b1, 13'($urandom)};
         else if (r < 50) ins = 14'h1C00 | 14'($urandom_range(0, 1023));
         else if (r < 70) ins = 14'h0180;
         else             ins = {1'b0, 13'($urandom)};
         step(($urandom % 100) == 0, ($urandom % 8) != 0, ins,
              1'($urandom), 1'($urandom), 1'($urandom),
              ($urandom % 20) == 0, int'($urandom_range(0, MODV - 1)),
              ($urandom % 10) == 0);
      end

      @(negedge clk);
      @(negedge clk);
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain: got %0d pending expected 0", exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
